// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - default operand width
//   - opcode encodings as presented on i_op
//   - FSM state encoding
package hilo_muldiv_unit_pkg;

    localparam int DEFAULT_MULDIV_DATA_SIZE = 32;

    localparam logic [1:0] MULDIV_OP_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_OP_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_OP_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/hilo_muldiv_unit_sign_adjust.sv
// Combinational sign handling around the unsigned multiply/divide core.
// Input side : operand_a/operand_b, is_signed -> abs_a/abs_b, sign_a/sign_b
// Output side: raw_result ({remainder,quotient} or 2W product), result_is_div,
//              res_sign_a/res_sign_b (captured at start) -> fixed_hi/fixed_lo
module hilo_muldiv_unit_sign_adjust #(
    parameter int DATA_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0]   operand_a,
    input  logic [DATA_SIZE-1:0]   operand_b,
    input  logic                   is_signed,
    output logic [DATA_SIZE-1:0]   abs_a,
    output logic [DATA_SIZE-1:0]   abs_b,
    output logic                   sign_a,
    output logic                   sign_b,
    input  logic [2*DATA_SIZE-1:0] raw_result,
    input  logic                   result_is_div,
    input  logic                   res_sign_a,
    input  logic                   res_sign_b,
    output logic [DATA_SIZE-1:0]   fixed_hi,
    output logic [DATA_SIZE-1:0]   fixed_lo
);

    logic                   negate_result;
    logic [DATA_SIZE-1:0]   quotient;
    logic [DATA_SIZE-1:0]   remainder;
    logic [2*DATA_SIZE-1:0] product_fixed;

    // Unsigned ops never report a sign, so the fix stage leaves them alone.
    assign sign_a = is_signed & operand_a[DATA_SIZE-1];
    assign sign_b = is_signed & operand_b[DATA_SIZE-1];

    // The most negative value maps onto itself; read as unsigned it is the
    // correct magnitude, which is what makes 0x80000000 / -1 wrap naturally.
    assign abs_a = sign_a ? -operand_a : operand_a;
    assign abs_b = sign_b ? -operand_b : operand_b;

    assign negate_result = res_sign_a ^ res_sign_b;
    assign quotient      = raw_result[DATA_SIZE-1:0];
    assign remainder     = raw_result[2*DATA_SIZE-1:DATA_SIZE];
    assign product_fixed = negate_result ? -raw_result : raw_result;

    always_comb begin
        fixed_hi = product_fixed[2*DATA_SIZE-1:DATA_SIZE];
        fixed_lo = product_fixed[DATA_SIZE-1:0];
        if (result_is_div) begin
            // Remainder follows the dividend, quotient follows the sign product.
            fixed_hi = res_sign_a ? -remainder : remainder;
            fixed_lo = negate_result ? -quotient : quotient;
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit with the architectural HI/LO pair.
// One shift-add or restoring-divide step per clock, then a sign-fix edge.
//
// Ports:
//   i_clk, i_reset (async, active low), i_flush (sync abort)
//   i_start, i_op, i_operand_a, i_operand_b : operation request (IDLE only)
//   i_mthi, i_mtlo, i_bus_wr                : HI/LO writes (IDLE, no start)
//   o_hi, o_lo                              : HI/LO registers
//   o_busy, o_done, o_div_by_zero           : status
//
// state   | meaning
// IDLE    | waiting for i_start, accepts MTHI/MTLO
// MUL     | shift-add iterations, counter running
// DIV     | restoring-divide iterations, counter running
// FIX     | sign fix, write HI/LO, pulse o_done
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int DATA_SIZE  = DEFAULT_MULDIV_DATA_SIZE,
    parameter int ITERATIONS = DATA_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_flush,
    input  logic                 i_start,
    input  logic [1:0]           i_op,
    input  logic [DATA_SIZE-1:0] i_operand_a,
    input  logic [DATA_SIZE-1:0] i_operand_b,
    input  logic                 i_mthi,
    input  logic                 i_mtlo,
    input  logic [DATA_SIZE-1:0] i_bus_wr,
    output logic [DATA_SIZE-1:0] o_hi,
    output logic [DATA_SIZE-1:0] o_lo,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_div_by_zero
);

    localparam int CW = $clog2(ITERATIONS + 1);
    localparam int W  = DATA_SIZE;

    muldiv_state_e state_q;
    muldiv_state_e state_d;

    logic [CW-1:0]  count_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   operand_q;
    logic           is_div_q;
    logic           sign_a_q;
    logic           sign_b_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic           busy_q;
    logic           done_q;
    logic           dz_q;

    logic           op_is_div;
    logic           op_is_signed;
    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;
    logic           sign_a;
    logic           sign_b;
    logic [W-1:0]   fixed_hi;
    logic [W-1:0]   fixed_lo;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_trial;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;
    logic           last_step;

    assign op_is_div    = (i_op == MULDIV_OP_DIV) || (i_op == MULDIV_OP_DIVU);
    assign op_is_signed = (i_op == MULDIV_OP_MULT) || (i_op == MULDIV_OP_DIV);

    hilo_muldiv_unit_sign_adjust #(
        .DATA_SIZE (W)
    ) u_sign_adjust (
        .operand_a     (i_operand_a),
        .operand_b     (i_operand_b),
        .is_signed     (op_is_signed),
        .abs_a         (abs_a),
        .abs_b         (abs_b),
        .sign_a        (sign_a),
        .sign_b        (sign_b),
        .raw_result    (acc_q),
        .result_is_div (is_div_q),
        .res_sign_a    (sign_a_q),
        .res_sign_b    (sign_b_q),
        .fixed_hi      (fixed_hi),
        .fixed_lo      (fixed_lo)
    );

    // Multiply: acc = {partial product, remaining multiplier bits}. The
    // carry out of the add is shifted back in as the new top bit.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide: acc = {remainder, dividend/quotient}. The shifted remainder
    // needs one extra bit before the trial subtract.
    assign div_trial = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff  = div_trial - {1'b0, operand_q};
    assign div_next  = div_diff[W] ? {div_trial[W-1:0], acc_q[W-2:0], 1'b0}
                                   : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};

    assign last_step = (count_q == CW'(1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = op_is_div ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                if (last_step) begin
                    state_d = ST_FIX;
                end
            end
            ST_DIV: begin
                if (last_step) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (i_flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count_q   <= '0;
            acc_q     <= '0;
            operand_q <= '0;
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            // Busy covers the iteration edges and drops on the FIX edge,
            // together with the o_done rise.
            busy_q <= ((state_q == ST_MUL) || (state_q == ST_DIV)) && !i_flush;
            if (!i_flush) begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_start) begin
                            count_q  <= CW'(ITERATIONS);
                            is_div_q <= op_is_div;
                            sign_a_q <= sign_a;
                            sign_b_q <= sign_b;
                            if (op_is_div) begin
                                acc_q     <= {{W{1'b0}}, abs_a};
                                operand_q <= abs_b;
                            end else begin
                                acc_q     <= {{W{1'b0}}, abs_b};
                                operand_q <= abs_a;
                            end
                        end else begin
                            if (i_mthi) begin
                                hi_q <= i_bus_wr;
                            end
                            if (i_mtlo) begin
                                lo_q <= i_bus_wr;
                            end
                        end
                    end
                    ST_MUL: begin
                        acc_q   <= mul_next;
                        count_q <= count_q - CW'(1);
                    end
                    ST_DIV: begin
                        acc_q   <= div_next;
                        count_q <= count_q - CW'(1);
                    end
                    ST_FIX: begin
                        done_q <= 1'b1;
                        // With a zero divisor the remainder is |a| and the
                        // dividend-sign fix restores the captured a exactly.
                        hi_q   <= fixed_hi;
                        if (is_div_q && (operand_q == '0)) begin
                            lo_q <= '1;
                            dz_q <= 1'b1;
                        end else begin
                            lo_q <= fixed_lo;
                        end
                    end
                    default: begin
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

    assign o_hi          = hi_q;
    assign o_lo          = lo_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_div_by_zero = dz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    localparam int NV = 11;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_operand_a = '0;
    logic [31:0] i_operand_b = '0;
    logic        i_mthi = 1'b0;
    logic        i_mtlo = 1'b0;
    logic [31:0] i_bus_wr = '0;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_busy;
    logic        o_done;
    logic        o_div_by_zero;

    int checks = 0;
    int failures = 0;

    vec_t vecs [NV];

    hilo_muldiv_unit dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_flush       (i_flush),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_operand_a   (i_operand_a),
        .i_operand_b   (i_operand_b),
        .i_mthi        (i_mthi),
        .i_mtlo        (i_mtlo),
        .i_bus_wr      (i_bus_wr),
        .o_hi          (o_hi),
        .o_lo          (o_lo),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Caller sits 1 time unit after a rising edge; returns the same way after E0.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_op        = op;
        i_operand_a = a;
        i_operand_b = b;
        i_start     = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int first_edge, output int edges, output int busy_cnt,
                             output logic seen, output logic [31:0] hi, output logic [31:0] lo,
                             output logic dz, output logic busy_at_done);
        edges = first_edge;
        busy_cnt = 0;
        seen = 1'b0;
        hi = '0;
        lo = '0;
        dz = 1'b0;
        busy_at_done = 1'b0;
        while (!seen && edges < first_edge + 60) begin
            @(posedge i_clk);
            #1;
            edges++;
            if (o_busy) busy_cnt++;
            if (o_done) begin
                seen = 1'b1;
                hi = o_hi;
                lo = o_lo;
                dz = o_div_by_zero;
                busy_at_done = o_busy;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int edges, busy_cnt;
        logic seen, dz, bsy;
        logic [31:0] hi, lo;
        start_op(v.op, v.a, v.b);
        wait_done(0, edges, busy_cnt, seen, hi, lo, dz, bsy);
        check({v.name, " done_seen"}, 32'(seen), 32'd1);
        check({v.name, " done_edge"}, 32'(edges), 32'd33);
        check({v.name, " busy_cycles"}, 32'(busy_cnt), 32'd32);
        check({v.name, " busy_at_done"}, 32'(bsy), 32'd0);
        check({v.name, " hi"}, hi, v.hi);
        check({v.name, " lo"}, lo, v.lo);
        check({v.name, " div_by_zero"}, 32'(dz), 32'(v.dz));
        @(posedge i_clk);
        #1;
        check({v.name, " done_one_cycle"}, 32'(o_done), 32'd0);
        check({v.name, " dz_one_cycle"}, 32'(o_div_by_zero), 32'd0);
    endtask

    initial begin
        int edges, busy_cnt;
        logic seen, dz, bsy, saw_done;
        logic [31:0] hi, lo;
        vec_t post;

        vecs[0]  = '{"mult_neg3_x7",     2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{"multu_max_x_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2]  = '{"div_neg7_by2",     2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{"div_overflow",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4]  = '{"divu_100_by0",     2'b11, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{"div_neg5_by0",     2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{"div_7_byneg2",     2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[7]  = '{"divu_100_by7",     2'b11, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[8]  = '{"mult_min_x_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{"multu_2p31_x2",    2'b01, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[10] = '{"mult_5_x6",        2'b00, 32'd5,         32'd6,        32'h0000_0000, 32'h0000_001E, 1'b0};

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("reset hi", o_hi, 32'd0);
        check("reset lo", o_lo, 32'd0);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset done", 32'(o_done), 32'd0);
        check("reset dz", 32'(o_div_by_zero), 32'd0);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // MTHI then MTLO in IDLE
        i_mthi = 1'b1;
        i_bus_wr = 32'h0000_1234;
        @(posedge i_clk);
        #1;
        i_mthi = 1'b0;
        check("mthi hi", o_hi, 32'h0000_1234);
        check("mthi lo_kept", o_lo, 32'h0000_001E);
        i_mtlo = 1'b1;
        i_bus_wr = 32'h0000_5678;
        @(posedge i_clk);
        #1;
        i_mtlo = 1'b0;
        check("mtlo lo", o_lo, 32'h0000_5678);
        check("mtlo hi_kept", o_hi, 32'h0000_1234);

        // While busy: MTHI and a second start are ignored
        start_op(2'b01, 32'd3, 32'd4);
        repeat (3) @(posedge i_clk);
        #1;
        i_mthi = 1'b1;
        i_bus_wr = 32'h0000_AAAA;
        i_op = 2'b11;
        i_operand_a = 32'd100;
        i_operand_b = 32'd7;
        i_start = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_mthi = 1'b0;
        i_start = 1'b0;
        check("busy mthi_ignored", o_hi, 32'h0000_1234);
        check("busy no_bypass_lo", o_lo, 32'h0000_5678);
        wait_done(5, edges, busy_cnt, seen, hi, lo, dz, bsy);
        check("busy_ign done_seen", 32'(seen), 32'd1);
        check("busy_ign done_edge", 32'(edges), 32'd33);
        check("busy_ign hi", hi, 32'h0000_0000);
        check("busy_ign lo", lo, 32'h0000_000C);
        repeat (3) @(posedge i_clk);
        #1;
        check("busy_ign no_second_op", 32'(o_busy), 32'd0);

        // Both MT together
        i_mthi = 1'b1;
        i_mtlo = 1'b1;
        i_bus_wr = 32'h0000_9999;
        @(posedge i_clk);
        #1;
        i_mthi = 1'b0;
        i_mtlo = 1'b0;
        check("mt_both hi", o_hi, 32'h0000_9999);
        check("mt_both lo", o_lo, 32'h0000_9999);

        // Flush mid-MULT
        i_mthi = 1'b1;
        i_bus_wr = 32'h0000_1111;
        @(posedge i_clk);
        #1;
        i_mthi = 1'b0;
        i_mtlo = 1'b1;
        i_bus_wr = 32'h0000_2222;
        @(posedge i_clk);
        #1;
        i_mtlo = 1'b0;
        start_op(2'b00, 32'd5, 32'd6);
        repeat (10) @(posedge i_clk);
        #1;
        check("flush busy_before", 32'(o_busy), 32'd1);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        check("flush busy_dropped", 32'(o_busy), 32'd0);
        check("flush done_low", 32'(o_done), 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge i_clk);
            #1;
            if (o_done || o_busy) saw_done = 1'b1;
        end
        check("flush no_done", 32'(saw_done), 32'd0);
        check("flush hi_kept", o_hi, 32'h0000_1111);
        check("flush lo_kept", o_lo, 32'h0000_2222);

        // Flush in the same cycle as start and MTHI drops both
        i_flush = 1'b1;
        i_start = 1'b1;
        i_op = 2'b00;
        i_mthi = 1'b1;
        i_bus_wr = 32'h0000_7777;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_start = 1'b0;
        i_mthi = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("flush_start busy", 32'(o_busy), 32'd0);
        check("flush_mthi hi", o_hi, 32'h0000_1111);

        // Asynchronous reset mid-DIV
        start_op(2'b10, 32'd100, 32'd7);
        repeat (15) @(posedge i_clk);
        #1;
        check("rst_mid busy_before", 32'(o_busy), 32'd1);
        i_reset = 1'b0;
        #1;
        check("rst_mid hi", o_hi, 32'd0);
        check("rst_mid lo", o_lo, 32'd0);
        check("rst_mid busy", 32'(o_busy), 32'd0);
        check("rst_mid done", 32'(o_done), 32'd0);
        check("rst_mid dz", 32'(o_div_by_zero), 32'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;

        post = '{"post_reset_divu", 2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0};
        run_vec(post);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
